// File: rtl/lifo_pkg.sv
// Shared definitions for the stack command front-end: op encodings,
// controller state type and default geometry.
package lifo_pkg;

    localparam int LIFO_DEPTH = 4;
    localparam int LIFO_DW    = 4;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CLR  = 2'b10,
        OP_RSV  = 2'b11
    } lifo_op_t;

    typedef enum logic [1:0] {
        FLUSH = 2'b00,
        IDLE  = 2'b01,
        POPW  = 2'b10,
        RESP  = 2'b11
    } lifo_ctrl_state_t;

endpackage

// File: rtl/lifo_cmd_ctrl.sv
// Command front-end for the attached stack: valid/ready request in, one
// registered response out per command, with a mirrored occupancy count.
//
// state | meaning
// FLUSH | stack being reset after Rst, no commands taken
// IDLE  | ready for a command; pins driven from the request
// POPW  | stack holds dataOut for one cycle while it is captured
// RESP  | response presented until rsp_ready
module lifo_cmd_ctrl
    import lifo_pkg::*;
#(
    parameter int DEPTH = LIFO_DEPTH,
    parameter int DW    = LIFO_DW,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [CW-1:0] occ,
    output logic          sync_err,
    output logic [DW-1:0] lifo_din,
    output logic          lifo_rw,
    output logic          lifo_en,
    output logic          lifo_rst,
    input  logic [DW-1:0] lifo_dout,
    input  logic          lifo_empty,
    input  logic          lifo_full
);

    lifo_ctrl_state_t state, state_nxt;
    logic [CW-1:0]    occ_nxt;
    logic             rsp_valid_nxt, rsp_err_nxt, sync_err_nxt;
    logic [DW-1:0]    rsp_data_nxt;
    logic             chk_skip, chk_skip_nxt;
    logic             lifo_full_unused;

    localparam logic [CW-1:0] OCC_MAX = CW'(DEPTH);

    assign lifo_full_unused = lifo_full;

    always_ff @(posedge clk) begin
        if (Rst) begin
            state     <= FLUSH;
            occ       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            sync_err  <= 1'b0;
            chk_skip  <= 1'b1;
        end else begin
            state     <= state_nxt;
            occ       <= occ_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
            sync_err  <= sync_err_nxt;
            chk_skip  <= chk_skip_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        occ_nxt       = occ;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        sync_err_nxt  = sync_err;
        chk_skip_nxt  = chk_skip;
        req_ready     = 1'b0;
        lifo_en       = 1'b0;
        lifo_rst      = 1'b0;
        lifo_rw       = 1'b0;
        lifo_din      = '0;

        case (state)
            FLUSH: begin
                lifo_en      = 1'b1;
                lifo_rst     = 1'b1;
                chk_skip_nxt = 1'b1;
                state_nxt    = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                // stack may lag one cycle behind a reset; skip that cycle
                if (chk_skip)
                    chk_skip_nxt = 1'b0;
                else if ((occ == '0) != lifo_empty)
                    sync_err_nxt = 1'b1;
                if (req_valid) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = '0;
                    rsp_err_nxt   = 1'b0;
                    state_nxt     = RESP;
                    case (lifo_op_t'(req_op))
                        OP_PUSH: begin
                            if (occ < OCC_MAX) begin
                                lifo_en  = 1'b1;
                                lifo_din = req_data;
                                occ_nxt  = occ + CW'(1);
                            end else begin
                                rsp_err_nxt = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (occ != '0) begin
                                lifo_en       = 1'b1;
                                lifo_rw       = 1'b1;
                                occ_nxt       = occ - CW'(1);
                                rsp_valid_nxt = 1'b0;
                                state_nxt     = POPW;
                            end else begin
                                rsp_err_nxt = 1'b1;
                            end
                        end
                        OP_CLR: begin
                            lifo_en      = 1'b1;
                            lifo_rst     = 1'b1;
                            occ_nxt      = '0;
                            sync_err_nxt = 1'b0;
                            chk_skip_nxt = 1'b1;
                        end
                        default: rsp_err_nxt = 1'b1;
                    endcase
                end
            end
            POPW: begin
                rsp_data_nxt  = lifo_dout;
                rsp_err_nxt   = 1'b0;
                rsp_valid_nxt = 1'b1;
                state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = FLUSH;
        endcase

        if (Rst) begin
            req_ready = 1'b0;
            lifo_en   = 1'b1;
            lifo_rst  = 1'b1;
            lifo_rw   = 1'b0;
            lifo_din  = '0;
        end
    end

endmodule

// File: tb/tb_lifo_cmd_ctrl.sv
// Bench for lifo_cmd_ctrl: behavioural stack on the pins, queue-based
// reference stack, scoreboard of expected responses checked by a monitor.
module tb_lifo_cmd_ctrl;

    logic       clk = 1'b0;
    logic       Rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic [2:0] occ;
    logic       sync_err;
    logic [3:0] lifo_din;
    logic       lifo_rw;
    logic       lifo_en;
    logic       lifo_rst;
    logic [3:0] lifo_dout;
    logic       lifo_empty;
    logic       lifo_full;

    lifo_cmd_ctrl dut (
        .clk(clk), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .occ(occ), .sync_err(sync_err),
        .lifo_din(lifo_din), .lifo_rw(lifo_rw), .lifo_en(lifo_en), .lifo_rst(lifo_rst),
        .lifo_dout(lifo_dout), .lifo_empty(lifo_empty), .lifo_full(lifo_full)
    );

    always #5 clk = ~clk;

    // attached 4-deep stack
    logic [3:0] stk_mem [4];
    int         stk_cnt = 0;
    logic [3:0] stk_dout = 4'h0;
    always @(posedge clk) begin
        if (lifo_en) begin
            if (lifo_rst) begin
                stk_cnt  <= 0;
                stk_dout <= 4'h0;
            end else if (!lifo_rw) begin
                if (stk_cnt < 4) begin
                    stk_mem[stk_cnt] <= lifo_din;
                    stk_cnt          <= stk_cnt + 1;
                end
            end else if (stk_cnt > 0) begin
                stk_dout <= stk_mem[stk_cnt-1];
                stk_cnt  <= stk_cnt - 1;
            end
        end
    end
    assign lifo_dout  = stk_dout;
    assign lifo_empty = (stk_cnt == 0);
    assign lifo_full  = (stk_cnt == 4);

    typedef struct {
        logic [3:0] data;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] model[$];
    int         vec = 0;
    int         miss = 0;
    int         cyc = 0;
    int         hs_cyc = 0;
    int         rdy_mode = 0;

    always @(posedge clk) cyc++;

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 9) < 7);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // response monitor
    logic       in_rsp = 1'b0;
    logic       held = 1'b0;
    logic [3:0] held_data;
    logic       held_err;
    always @(negedge clk) begin
        if (Rst) begin
            in_rsp = 1'b0;
            held   = 1'b0;
        end else begin
            if (held) begin
                vec++;
                if (!rsp_valid || rsp_data !== held_data || rsp_err !== held_err) begin
                    miss++;
                    $display("FAIL rsp_hold: got v=%b d=%h e=%b, need v=1 d=%h e=%b",
                             rsp_valid, rsp_data, rsp_err, held_data, held_err);
                end
            end
            if (rsp_valid) begin
                vec++;
                if (req_ready !== 1'b0 || sync_err !== 1'b0) begin
                    miss++;
                    $display("FAIL busy_flags: got req_ready=%b sync_err=%b, need 0 0",
                             req_ready, sync_err);
                end
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    vec++;
                    if (exp_q.size() == 0) begin
                        miss++;
                        $display("FAIL unexpected_rsp: got d=%h e=%b, need no response",
                                 rsp_data, rsp_err);
                    end else if (cyc - hs_cyc != exp_q[0].lat) begin
                        miss++;
                        $display("FAIL rsp_latency: got %0d, need %0d",
                                 cyc - hs_cyc, exp_q[0].lat);
                    end
                end
                if (rsp_ready) begin
                    in_rsp = 1'b0;
                    if (exp_q.size() != 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        vec++;
                        if (rsp_data !== e.data || rsp_err !== e.err) begin
                            miss++;
                            $display("FAIL rsp_value: got d=%h e=%b, need d=%h e=%b",
                                     rsp_data, rsp_err, e.data, e.err);
                        end
                    end
                end
            end
            held      = rsp_valid && !rsp_ready;
            held_data = rsp_data;
            held_err  = rsp_err;
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] need);
        vec++;
        if (got !== need) begin
            miss++;
            $display("FAIL %s: got %h, need %h", name, got, need);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] d);
        int   n = 0;
        exp_t e;
        logic x_en = 1'b0, x_rw = 1'b0, x_rst = 1'b0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 8'(req_ready), 8'h1);
            return;
        end
        e.data = 4'h0;
        e.err  = 1'b0;
        e.lat  = 0;
        case (op)
            2'b00: if (model.size() < 4) begin
                       model.push_back(d);
                       x_en = 1'b1;
                   end else e.err = 1'b1;
            2'b01: if (model.size() > 0) begin
                       e.data = model.pop_back();
                       e.lat  = 1;
                       x_en   = 1'b1;
                       x_rw   = 1'b1;
                   end else e.err = 1'b1;
            2'b10: begin
                       model.delete();
                       x_en  = 1'b1;
                       x_rst = 1'b1;
                   end
            default: e.err = 1'b1;
        endcase
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        exp_q.push_back(e);
        #1;
        check("stack_pins", {lifo_din, 1'b0, lifo_en, lifo_rw, lifo_rst},
              {(x_en && !x_rw && !x_rst) ? d : 4'h0, 1'b0, x_en, x_rw, x_rst});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        hs_cyc    = cyc;
        check("occ", 8'(occ), 8'(model.size()));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 8'(exp_q.size()), 8'h0);
    endtask

    initial begin
        Rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {occ, rsp_valid, sync_err, lifo_en, lifo_rst, req_ready},
              {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1 Rst = 1'b0;
        @(negedge clk);
        check("flush_pins", {lifo_en, lifo_rst, req_ready}, {1'b1, 1'b1, 1'b0});

        // fill, overflow, drain, underflow
        issue(2'b00, 4'h3);
        issue(2'b00, 4'h5);
        issue(2'b00, 4'h9);
        issue(2'b00, 4'hC);
        issue(2'b00, 4'h7);
        repeat (5) issue(2'b01, 4'h0);
        drain();

        // back-pressure on a push response
        rdy_mode = 2;
        issue(2'b00, 4'hA);
        repeat (5) @(negedge clk);
        check("bp_valid", {rsp_valid, req_ready}, {1'b1, 1'b0});
        rdy_mode = 0;
        drain();

        // push, clear, pop on empty, reserved op
        issue(2'b00, 4'h2);
        issue(2'b10, 4'h0);
        issue(2'b01, 4'h0);
        issue(2'b11, 4'h0);
        drain();

        rdy_mode = 1;
        repeat (300) begin
            int r;
            r = $urandom_range(0, 9);
            issue(r < 4 ? 2'b00 : r < 8 ? 2'b01 : r == 8 ? 2'b10 : 2'b11, 4'($urandom));
        end
        rdy_mode = 0;
        drain();

        // reset while a pop is waiting for its data
        issue(2'b00, 4'h4);
        drain();
        issue(2'b01, 4'h0);
        Rst = 1'b1;
        exp_q.delete();
        model.delete();
        @(negedge clk);
        check("rst_popw_pins", {lifo_en, lifo_rst, rsp_valid}, {1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1 Rst = 1'b0;
        @(negedge clk);
        check("rst_popw_flush", {occ, rsp_valid, lifo_rst, req_ready},
              {3'd0, 1'b0, 1'b1, 1'b0});
        issue(2'b00, 4'h6);
        issue(2'b01, 4'h0);
        issue(2'b01, 4'h0);
        drain();
        repeat (3) @(negedge clk);
        check("sync_err_end", {sync_err, occ}, {1'b0, 3'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
